mem_access_unit: RTL and testbench

- Load/store front end sitting directly upstream of data_memory in the MIPS MEM stage.
- Accepts byte/halfword/word load and store requests from the EX/MEM pipeline register.
- Drives data_memory's word-wide port (address, write_data, MemWrite, MemRead, read_data), using read-modify-write for sub-word stores.
- Returns extracted and extended load data to the writeback path; flags misaligned accesses.

---
 rtl/mem_access_unit.sv | 151 +++++++++++++++
 tb/tb_mem_access_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store front end for data_memory: byte/half/word loads with extension,
// word stores, and read-modify-write for sub-word stores. Misaligned requests
// are rejected with a single-cycle pulse and never touch memory.

// Per byte lane store merge: replaces the old byte with store data when the
// request targets this lane, otherwise passes the memory byte through.
module mem_lane_merge #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  offs,
  input  logic [15:0] wdata,
  input  logic [7:0]  old_byte,
  output logic [7:0]  new_byte
);
  localparam logic [1:0] LN = LANE[1:0];
  logic hit;

  // lane hit for byte (exact offset) or half (same half-word) stores
  always_comb begin
    hit = ((size == 2'b00) && (offs == LN)) ||
          ((size == 2'b01) && (offs[1] == LN[1]));
    new_byte = old_byte;
    if (hit) new_byte = ((size == 2'b00) || !LN[0]) ? wdata[7:0] : wdata[15:8];
  end
endmodule

module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  misaligned,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  output logic                  MemWrite,
  output logic                  MemRead,
  input  logic [31:0]           mem_read_data
);
  localparam int NUM_LANES = DATA_WIDTH / 8;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] STORE  = 3'd2;
  localparam logic [2:0] RMW_RD = 3'd3;
  localparam logic [2:0] RMW_WR = 3'd4;
  localparam logic [2:0] ERR    = 3'd5;

  logic [2:0]  state;
  logic [1:0]  cap_size;
  logic        cap_signed;
  logic [1:0]  cap_offs;
  logic [31:0] cap_wdata;
  logic [31:0] merge_word;
  logic [31:0] merged;
  logic [31:0] load_ext;
  logic [31:0] shifted;
  logic        req_mis;

  // alignment check on the incoming request
  always_comb begin
    req_mis = (req_size == 2'b11) ||
              ((req_size == 2'b01) && req_addr[0]) ||
              ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // lane extraction and sign/zero extension of the word being read
  always_comb begin
    shifted  = mem_read_data >> {cap_offs, 3'b000};
    load_ext = mem_read_data;
    case (cap_size)
      2'b00:   load_ext = {{24{cap_signed & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{cap_signed & shifted[15]}}, shifted[15:0]};
      default: load_ext = mem_read_data;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      mem_lane_merge #(.LANE(gi)) u_merge (
        .size     (cap_size),
        .offs     (cap_offs),
        .wdata    (cap_wdata[15:0]),
        .old_byte (merge_word[8*gi +: 8]),
        .new_byte (merged[8*gi +: 8])
      );
    end
  endgenerate

  // memory strobes gated by reset so nothing is committed while resetting
  always_comb begin
    req_ready      = (state == IDLE);
    misaligned     = (state == ERR);
    MemRead        = !reset && ((state == LOAD) || (state == RMW_RD));
    MemWrite       = !reset && ((state == STORE) || (state == RMW_WR));
    mem_write_data = '0;
    if (state == STORE)  mem_write_data = cap_wdata;
    if (state == RMW_WR) mem_write_data = merged;
  end

  // request capture, FSM sequencing and load response register
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cap_size    <= '0;
      cap_signed  <= 1'b0;
      cap_offs    <= '0;
      cap_wdata   <= '0;
      merge_word  <= '0;
      mem_address <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          cap_size    <= req_size;
          cap_signed  <= req_signed;
          cap_offs    <= req_addr[1:0];
          cap_wdata   <= req_wdata;
          mem_address <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
          if (req_mis)                 state <= ERR;
          else if (!req_write)         state <= LOAD;
          else if (req_size == 2'b10)  state <= STORE;
          else                         state <= RMW_RD;
        end
        LOAD: begin
          resp_valid <= 1'b1;
          resp_rdata <= load_ext;
          state      <= IDLE;
        end
        RMW_RD: begin
          merge_word <= mem_read_data;
          state      <= RMW_WR;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word-array memory model, scoreboard of expected
// load results, explicit latency/strobe checks around each scenario.
module tb_mem_access_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        misaligned;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:63] = '{default: 32'h0};
  logic [31:0] rq[$];
  int          mis_exp = 0;
  int          n_chk = 0;
  int          n_err = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          r0;
  int          w0;

  always #5 clock = ~clock;

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .misaligned(misaligned), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .MemWrite(MemWrite), .MemRead(MemRead),
    .mem_read_data(mem_read_data)
  );

  // data_memory model: combinational read, write at the closing edge
  assign mem_read_data = mem[mem_address[7:2]];
  always @(posedge clock) if (MemWrite) mem[mem_address[7:2]] <= mem_write_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // strobe counters and scoreboard pop
  always @(negedge clock) begin
    if (MemRead) rd_cnt++;
    if (MemWrite) wr_cnt++;
    if (resp_valid || misaligned) chk("excl", {31'b0, resp_valid & misaligned}, 32'h0);
    if (resp_valid) begin
      if (rq.size() == 0) chk("resp_unexp", 32'h1, 32'h0);
      else chk("resp_rdata", resp_rdata, rq.pop_front());
    end
    if (misaligned) begin
      chk("mis_unexp", {31'b0, mis_exp == 0}, 32'h0);
      if (mis_exp > 0) mis_exp--;
    end
  end

  // drive one request and return just after its accepting edge
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd);
    int t = 0;
    @(negedge clock);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    while (!req_ready && t < 50) begin @(negedge clock); t++; end
    if (t >= 50) chk("accept_timeout", 32'h0, 32'h1);
    @(posedge clock);
    #1;
    req_valid = 1'b0; req_write = $urandom; req_size = 2'($urandom);
    req_signed = $urandom; req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic do_load(input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] exp);
    rq.push_back(exp);
    do_req(1'b0, sz, sg, addr, 32'h0);
  endtask

  task automatic drain(input string tag);
    repeat (4) @(negedge clock);
    chk(tag, rq.size(), 32'h0);
    chk({tag, "_mis"}, mis_exp, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    // reset state
    repeat (2) @(negedge clock);
    chk("rst_ready", req_ready, 1); chk("rst_rvalid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0); chk("rst_mis", misaligned, 0);
    chk("rst_addr", mem_address, 0); chk("rst_wdata", mem_write_data, 0);
    chk("rst_mw", MemWrite, 0); chk("rst_mr", MemRead, 0);
    chk("rst_strobes", rd_cnt + wr_cnt, 0);
    reset = 1'b0;

    // word store then word load with latency checks
    w0 = wr_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'd8, 32'hDEADBEEF);
    @(negedge clock);
    chk("sw_mw", MemWrite, 1); chk("sw_addr", mem_address, 8);
    chk("sw_data", mem_write_data, 32'hDEADBEEF); chk("sw_busy", req_ready, 0);
    @(negedge clock);
    chk("sw_mw_end", MemWrite, 0); chk("sw_ready", req_ready, 1);
    chk("sw_wr_cnt", wr_cnt - w0, 1);
    do_load(2'b10, 1'b0, 32'd8, 32'hDEADBEEF);
    @(negedge clock);
    chk("lw_c1_mr", MemRead, 1); chk("lw_c1_rv", resp_valid, 0);
    @(negedge clock);
    chk("lw_c2_rv", resp_valid, 1); chk("lw_c2_ready", req_ready, 1);
    drain("lw_drain");

    // sub-word loads, back to back
    do_load(2'b00, 1'b1, 32'd9, 32'hFFFFFFBE);
    do_load(2'b00, 1'b0, 32'd9, 32'h000000BE);
    do_load(2'b01, 1'b1, 32'd10, 32'hFFFFDEAD);
    do_load(2'b01, 1'b0, 32'd10, 32'h0000DEAD);
    do_load(2'b00, 1'b0, 32'd8, 32'h000000EF);
    do_load(2'b01, 1'b1, 32'd8, 32'hFFFFBEEF);
    drain("sub_drain");

    // byte store via read-modify-write
    do_req(1'b1, 2'b00, 1'b0, 32'd11, 32'hFFFFFF12);
    @(negedge clock);
    chk("sb_c1_ready", req_ready, 0); chk("sb_c1_mr", MemRead, 1); chk("sb_c1_mw", MemWrite, 0);
    @(negedge clock);
    chk("sb_c2_ready", req_ready, 0); chk("sb_c2_mw", MemWrite, 1);
    chk("sb_c2_data", mem_write_data, 32'h12ADBEEF); chk("sb_c2_addr", mem_address, 8);
    @(negedge clock);
    chk("sb_c3_ready", req_ready, 1);
    do_req(1'b1, 2'b01, 1'b0, 32'd8, 32'h00005566);
    do_load(2'b10, 1'b0, 32'd8, 32'h12AD5566);
    drain("sh_drain");

    // misaligned requests
    r0 = rd_cnt; w0 = wr_cnt;
    mis_exp++; do_req(1'b0, 2'b10, 1'b0, 32'd6, 32'h0);
    @(negedge clock); chk("mis_lw_pulse", misaligned, 1);
    @(negedge clock); chk("mis_lw_end", misaligned, 0);
    mis_exp++; do_req(1'b1, 2'b01, 1'b0, 32'd5, 32'h1111);
    @(negedge clock); chk("mis_sh_pulse", misaligned, 1);
    mis_exp++; do_req(1'b0, 2'b11, 1'b0, 32'd0, 32'h0);
    @(negedge clock); chk("mis_sz3_pulse", misaligned, 1);
    drain("mis_drain");
    chk("mis_no_rd", rd_cnt - r0, 0); chk("mis_no_wr", wr_cnt - w0, 0);
    do_load(2'b10, 1'b0, 32'd8, 32'h12AD5566);
    drain("mis_mem");

    // reset during RMW_RD
    w0 = wr_cnt;
    do_req(1'b1, 2'b00, 1'b0, 32'd8, 32'h00000077);
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    chk("rrmw_ready", req_ready, 1); chk("rrmw_addr", mem_address, 0);
    repeat (3) @(negedge clock);
    chk("rrmw_no_wr", wr_cnt - w0, 0);
    do_load(2'b10, 1'b0, 32'd8, 32'h12AD5566);
    drain("rrmw_mem");

    // reset during LOAD: no response
    do_req(1'b0, 2'b10, 1'b0, 32'd8, 32'h0);
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    chk("rld_rv", resp_valid, 0); chk("rld_ready", req_ready, 1);
    drain("rld_drain");

    // req_valid while busy is ignored
    w0 = wr_cnt;
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000A1B2);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'hBAD0BAD0;
    @(negedge clock);
    @(negedge clock);
    chk("busy_addr", mem_address, 32'h10); chk("busy_data", mem_write_data, 32'hA1B20000);
    req_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("busy_wr_cnt", wr_cnt - w0, 1);
    do_load(2'b10, 1'b0, 32'h10, 32'hA1B20000);
    do_load(2'b10, 1'b0, 32'h20, 32'h00000000);
    drain("busy_drain");

    // top of address space
    do_req(1'b1, 2'b10, 1'b0, 32'hFFFFFFFC, 32'hCAFEF00D);
    @(negedge clock); chk("top_addr", mem_address, 32'hFFFFFFFC);
    do_load(2'b00, 1'b0, 32'hFFFFFFFF, 32'h000000CA);
    do_load(2'b01, 1'b1, 32'hFFFFFFFE, 32'hFFFFCAFE);
    drain("top_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
